// File: rtl/cva6_shared_tlb_assoc.sv
`default_nettype none
// ============================================================================
//  Module   : cva6_shared_tlb_assoc
//  Brief    : Set-associative second-level TLB shared by the instruction and
//             data L1 TLBs of an Sv39 MMU. One-stage lookup pipeline,
//             single-cycle PTW refill, tree-PLRU replacement per set and
//             sfence.vma flush by ASID and/or VPN.
//  Revision : 1.0 - initial release
// ============================================================================
module cva6_shared_tlb_assoc #(
    parameter int unsigned DEPTH      = 64,
    parameter int unsigned WAYS       = 2,
    parameter int unsigned VPN_WIDTH  = 27,
    parameter int unsigned PPN_WIDTH  = 44,
    parameter int unsigned ASID_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  dtlb_req_valid_i,
    output logic                  dtlb_req_ready_o,
    input  logic [VPN_WIDTH-1:0]  dtlb_vpn_i,
    input  logic                  itlb_req_valid_i,
    output logic                  itlb_req_ready_o,
    input  logic [VPN_WIDTH-1:0]  itlb_vpn_i,
    input  logic [ASID_WIDTH-1:0] asid_i,
    output logic                  resp_valid_o,
    output logic                  resp_port_o,
    output logic                  resp_hit_o,
    output logic [PPN_WIDTH-1:0]  resp_ppn_o,
    output logic [7:0]            resp_perm_o,
    input  logic                  fill_valid_i,
    input  logic [VPN_WIDTH-1:0]  fill_vpn_i,
    input  logic [ASID_WIDTH-1:0] fill_asid_i,
    input  logic [PPN_WIDTH-1:0]  fill_ppn_i,
    input  logic [7:0]            fill_perm_i,
    input  logic                  flush_i,
    input  logic                  flush_asid_valid_i,
    input  logic [ASID_WIDTH-1:0] flush_asid_i,
    input  logic                  flush_vpn_valid_i,
    input  logic [VPN_WIDTH-1:0]  flush_vpn_i
);

    localparam int unsigned c_SETS   = DEPTH / WAYS;
    localparam int unsigned c_IDX_W  = (c_SETS > 1) ? $clog2(c_SETS) : 1;
    localparam int unsigned c_WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned c_PLRU_W = (WAYS > 1) ? WAYS - 1 : 1;
    localparam int unsigned c_G_BIT  = 5;

    typedef logic [c_IDX_W-1:0]  set_t;
    typedef logic [c_WAY_W-1:0]  way_t;
    typedef logic [c_PLRU_W-1:0] plru_t;

    // Set index is the low VPN bits; a single-set TLB always uses set 0.
    function automatic set_t set_of(input logic [VPN_WIDTH-1:0] vpn);
        set_t s;
        s = '0;
        if (c_SETS > 1) s = vpn[c_IDX_W-1:0];
        return s;
    endfunction

    // Tree nodes are heap-ordered (children of n are 2n+1, 2n+2); a node bit
    // names the subtree holding the next victim, so touching a way points
    // every node on its path away from it.
    function automatic plru_t plru_touch(input plru_t tree, input way_t way);
        plru_t       t;
        int unsigned node;
        logic        b;
        t    = tree;
        node = 0;
        for (int unsigned l = 0; l < c_WAY_W; l++) begin
            b = way[c_WAY_W-1-l];
            for (int unsigned n = 0; n < c_PLRU_W; n++) begin
                if (n == node) t[n] = ~b;
            end
            node = 2 * node + 1 + {31'd0, b};
        end
        return t;
    endfunction

    // Follow the node bits from the root down to the victim leaf.
    function automatic way_t plru_victim(input plru_t tree);
        way_t        w;
        int unsigned node;
        logic        b;
        w    = '0;
        node = 0;
        if (WAYS > 1) begin
            for (int unsigned l = 0; l < c_WAY_W; l++) begin
                b = 1'b0;
                for (int unsigned n = 0; n < c_PLRU_W; n++) begin
                    if (n == node) b = tree[n];
                end
                w[c_WAY_W-1-l] = b;
                node = 2 * node + 1 + {31'd0, b};
            end
        end
        return w;
    endfunction

    // Entry storage
    logic [WAYS-1:0]       r_valid [c_SETS];
    logic [VPN_WIDTH-1:0]  r_tag   [c_SETS][WAYS];
    logic [ASID_WIDTH-1:0] r_asid  [c_SETS][WAYS];
    logic [PPN_WIDTH-1:0]  r_ppn   [c_SETS][WAYS];
    logic [7:0]            r_perm  [c_SETS][WAYS];
    plru_t                 r_plru  [c_SETS];

    // Response stage
    logic                  r_resp_valid;
    logic                  r_resp_port;
    logic                  r_resp_hit;
    logic [PPN_WIDTH-1:0]  r_resp_ppn;
    logic [7:0]            r_resp_perm;
    set_t                  r_resp_set;
    way_t                  r_resp_way;

    logic                  w_dtlb_fire;
    logic                  w_itlb_fire;
    logic                  w_lk_fire;
    logic [VPN_WIDTH-1:0]  w_lk_vpn;
    set_t                  w_lk_set;
    logic                  w_lk_hit;
    way_t                  w_lk_way;
    logic [PPN_WIDTH-1:0]  w_lk_ppn;
    logic [7:0]            w_lk_perm;

    logic                  w_fill_do;
    set_t                  w_fill_set;
    plru_t                 w_fill_tree;
    way_t                  w_fill_way;
    logic [WAYS-1:0]       w_flush_kill [c_SETS];

    // Flush and fill own the cycle; dtlb wins over itlb.
    assign dtlb_req_ready_o = rst_ni & ~flush_i & ~fill_valid_i;
    assign itlb_req_ready_o = dtlb_req_ready_o & ~dtlb_req_valid_i;
    assign w_dtlb_fire      = dtlb_req_valid_i & dtlb_req_ready_o;
    assign w_itlb_fire      = itlb_req_valid_i & itlb_req_ready_o;
    assign w_lk_fire        = w_dtlb_fire | w_itlb_fire;
    assign w_lk_vpn         = w_dtlb_fire ? dtlb_vpn_i : itlb_vpn_i;
    assign w_lk_set         = set_of(w_lk_vpn);
    // A fill colliding with a flush is dropped; the walker re-walks.
    assign w_fill_do        = fill_valid_i & ~flush_i;
    assign w_fill_set       = set_of(fill_vpn_i);

    // Lookup compare against the current entry state; lowest matching way wins.
    always_comb begin
        w_lk_hit  = 1'b0;
        w_lk_way  = '0;
        w_lk_ppn  = '0;
        w_lk_perm = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_lk_set][w] && (r_tag[w_lk_set][w] == w_lk_vpn) &&
                (r_perm[w_lk_set][w][c_G_BIT] || (r_asid[w_lk_set][w] == asid_i))) begin
                w_lk_hit  = 1'b1;
                w_lk_way  = way_t'(w);
                w_lk_ppn  = r_ppn[w_lk_set][w];
                w_lk_perm = r_perm[w_lk_set][w];
            end
        end
    end

    // Fill way choice: matching way, else lowest invalid way, else PLRU victim
    // taken from the tree after any same-cycle hit update.
    always_comb begin
        w_fill_tree = r_plru[w_fill_set];
        if (r_resp_valid && r_resp_hit && (r_resp_set == w_fill_set)) begin
            w_fill_tree = plru_touch(w_fill_tree, r_resp_way);
        end
        w_fill_way = plru_victim(w_fill_tree);
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_fill_set][w]) w_fill_way = way_t'(w);
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w_fill_set][w] && (r_tag[w_fill_set][w] == fill_vpn_i) &&
                (r_perm[w_fill_set][w][c_G_BIT] || (r_asid[w_fill_set][w] == fill_asid_i))) begin
                w_fill_way = way_t'(w);
            end
        end
    end

    // Per-entry flush match; an absent qualifier matches everything, and an
    // ASID qualifier never matches global entries.
    always_comb begin
        for (int unsigned s = 0; s < c_SETS; s++) begin
            for (int unsigned w = 0; w < WAYS; w++) begin
                w_flush_kill[s][w] =
                    (!flush_vpn_valid_i || (r_tag[s][w] == flush_vpn_i)) &&
                    (!flush_asid_valid_i ||
                     (!r_perm[s][w][c_G_BIT] && (r_asid[s][w] == flush_asid_i)));
            end
        end
    end

    // Valid bits: reset clears, flush invalidates matches, fill sets one.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int unsigned s = 0; s < c_SETS; s++) r_valid[s] <= '0;
        end else if (flush_i) begin
            for (int unsigned s = 0; s < c_SETS; s++) r_valid[s] <= r_valid[s] & ~w_flush_kill[s];
        end else if (w_fill_do) begin
            r_valid[w_fill_set][w_fill_way] <= 1'b1;
        end
    end

    // Entry payload written on fill; guarded by valid so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_fill_do) begin
            r_tag[w_fill_set][w_fill_way]  <= fill_vpn_i;
            r_asid[w_fill_set][w_fill_way] <= fill_asid_i;
            r_ppn[w_fill_set][w_fill_way]  <= fill_ppn_i;
            r_perm[w_fill_set][w_fill_way] <= fill_perm_i;
        end
    end

    if (WAYS > 1) begin : g_plru
        // Hit update first, then the fill update, which already folds in the hit.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                for (int unsigned s = 0; s < c_SETS; s++) r_plru[s] <= '0;
            end else begin
                if (r_resp_valid && r_resp_hit) begin
                    r_plru[r_resp_set] <= plru_touch(r_plru[r_resp_set], r_resp_way);
                end
                if (w_fill_do) begin
                    r_plru[w_fill_set] <= plru_touch(w_fill_tree, w_fill_way);
                end
            end
        end
    end else begin : g_no_plru
        // Direct-mapped: no replacement state.
        always_comb begin
            for (int unsigned s = 0; s < c_SETS; s++) r_plru[s] = '0;
        end
    end

    // Response register: one cycle after acceptance, zero payload on miss.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_resp_valid <= 1'b0;
            r_resp_port  <= 1'b0;
            r_resp_hit   <= 1'b0;
            r_resp_ppn   <= '0;
            r_resp_perm  <= '0;
            r_resp_set   <= '0;
            r_resp_way   <= '0;
        end else begin
            r_resp_valid <= w_lk_fire;
            r_resp_port  <= w_itlb_fire;
            r_resp_hit   <= w_lk_fire & w_lk_hit;
            r_resp_ppn   <= w_lk_fire ? w_lk_ppn : '0;
            r_resp_perm  <= w_lk_fire ? w_lk_perm : '0;
            r_resp_set   <= w_lk_set;
            r_resp_way   <= w_lk_way;
        end
    end

    assign resp_valid_o = r_resp_valid;
    assign resp_port_o  = r_resp_port;
    assign resp_hit_o   = r_resp_hit;
    assign resp_ppn_o   = r_resp_ppn;
    assign resp_perm_o  = r_resp_perm;

endmodule
`default_nettype wire

// File: tb/tb_cva6_shared_tlb_assoc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cva6_shared_tlb_assoc
//  Brief    : Self-checking bench for cva6_shared_tlb_assoc (DEPTH=4, WAYS=2)
//             with directed scenarios and a randomized run against a
//             behavioural model (per-set true LRU, identical to 2-way PLRU).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cva6_shared_tlb_assoc;
    localparam int DEPTH = 4;
    localparam int WAYS  = 2;
    localparam int SETS  = DEPTH / WAYS;

    logic        clk;
    logic        rst_n;
    logic        dv, dready, iv, iready;
    logic [26:0] dvpn, ivpn;
    logic [15:0] asid;
    logic        resp_valid, resp_port, resp_hit;
    logic [43:0] resp_ppn;
    logic [7:0]  resp_perm;
    logic        fill_valid;
    logic [26:0] fill_vpn;
    logic [15:0] fill_asid;
    logic [43:0] fill_ppn;
    logic [7:0]  fill_perm;
    logic        flush, flush_asid_valid, flush_vpn_valid;
    logic [15:0] flush_asid;
    logic [26:0] flush_vpn;

    cva6_shared_tlb_assoc #(
        .DEPTH(DEPTH), .WAYS(WAYS), .VPN_WIDTH(27), .PPN_WIDTH(44), .ASID_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .dtlb_req_valid_i(dv), .dtlb_req_ready_o(dready), .dtlb_vpn_i(dvpn),
        .itlb_req_valid_i(iv), .itlb_req_ready_o(iready), .itlb_vpn_i(ivpn),
        .asid_i(asid),
        .resp_valid_o(resp_valid), .resp_port_o(resp_port), .resp_hit_o(resp_hit),
        .resp_ppn_o(resp_ppn), .resp_perm_o(resp_perm),
        .fill_valid_i(fill_valid), .fill_vpn_i(fill_vpn), .fill_asid_i(fill_asid),
        .fill_ppn_i(fill_ppn), .fill_perm_i(fill_perm),
        .flush_i(flush), .flush_asid_valid_i(flush_asid_valid), .flush_asid_i(flush_asid),
        .flush_vpn_valid_i(flush_vpn_valid), .flush_vpn_i(flush_vpn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    bit          m_valid [SETS][WAYS];
    logic [26:0] m_tag   [SETS][WAYS];
    logic [15:0] m_asid  [SETS][WAYS];
    logic [43:0] m_ppn   [SETS][WAYS];
    logic [7:0]  m_perm  [SETS][WAYS];
    int          m_used  [SETS][WAYS];
    int          m_time;
    bit          p_touch;
    int          p_set, p_way;
    logic        e_valid, e_port, e_hit;
    logic [43:0] e_ppn;
    logic [7:0]  e_perm;

    task automatic idle();
        dv = 0; iv = 0; fill_valid = 0; flush = 0;
        flush_asid_valid = 0; flush_vpn_valid = 0;
    endtask

    // Advance the model by the cycle described by the current inputs, then clock.
    task automatic step();
        int          s, way;
        bit          kill;
        logic [26:0] v;
        if (!rst_n) begin
            foreach (m_valid[i, j]) begin m_valid[i][j] = 0; m_used[i][j] = 0; end
            m_time = 0; p_touch = 0;
            e_valid = 0; e_port = 0; e_hit = 0; e_ppn = 0; e_perm = 0;
        end else begin
            if (p_touch) begin m_time++; m_used[p_set][p_way] = m_time; end
            p_touch = 0;
            e_valid = 0; e_port = 0; e_hit = 0; e_ppn = 0; e_perm = 0;
            if (flush) begin
                foreach (m_valid[i, j]) begin
                    kill = 1;
                    if (flush_vpn_valid && m_tag[i][j] != flush_vpn) kill = 0;
                    if (flush_asid_valid && (m_perm[i][j][5] || m_asid[i][j] != flush_asid)) kill = 0;
                    if (kill) m_valid[i][j] = 0;
                end
            end else if (fill_valid) begin
                s = int'(fill_vpn % SETS);
                way = -1;
                for (int w = 0; w < WAYS; w++)
                    if (way < 0 && m_valid[s][w] && m_tag[s][w] == fill_vpn &&
                        (m_perm[s][w][5] || m_asid[s][w] == fill_asid)) way = w;
                for (int w = 0; w < WAYS; w++)
                    if (way < 0 && !m_valid[s][w]) way = w;
                if (way < 0) begin
                    way = 0;
                    for (int w = 1; w < WAYS; w++) if (m_used[s][w] < m_used[s][way]) way = w;
                end
                m_valid[s][way] = 1; m_tag[s][way] = fill_vpn; m_asid[s][way] = fill_asid;
                m_ppn[s][way] = fill_ppn; m_perm[s][way] = fill_perm;
                m_time++; m_used[s][way] = m_time;
            end else if (dv || iv) begin
                v = dv ? dvpn : ivpn;
                s = int'(v % SETS);
                e_valid = 1; e_port = !dv;
                for (int w = 0; w < WAYS; w++)
                    if (!e_hit && m_valid[s][w] && m_tag[s][w] == v &&
                        (m_perm[s][w][5] || m_asid[s][w] == asid)) begin
                        e_hit = 1; e_ppn = m_ppn[s][w]; e_perm = m_perm[s][w];
                        p_touch = 1; p_set = s; p_way = w;
                    end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle(); rst_n = 0; step(); rst_n = 1;
    endtask

    task automatic fill(input logic [26:0] v, input logic [15:0] a, input logic [43:0] p, input logic [7:0] f);
        fill_valid = 1; fill_vpn = v; fill_asid = a; fill_ppn = p; fill_perm = f;
        step(); fill_valid = 0;
    endtask

    task automatic look_d(input logic [26:0] v, input logic [15:0] a);
        dv = 1; dvpn = v; asid = a; step(); dv = 0;
    endtask

    task automatic do_flush(input bit av, input logic [15:0] a, input bit vv, input logic [26:0] v);
        flush = 1; flush_asid_valid = av; flush_asid = a; flush_vpn_valid = vv; flush_vpn = v;
        step(); flush = 0; flush_asid_valid = 0; flush_vpn_valid = 0;
    endtask

    task automatic test_reset();
        idle(); rst_n = 0; #1;
        vectors++;
        if ({dready, iready} !== 2'b00) begin
            miscompares++; $display("FAIL reset_ready: got %b required 00", {dready, iready});
        end
        step(); step();
        vectors++;
        if ({resp_valid, resp_port, resp_hit, resp_ppn, resp_perm} !== 55'd0) begin
            miscompares++; $display("FAIL reset_resp: got %h required 0",
                {resp_valid, resp_port, resp_hit, resp_ppn, resp_perm});
        end
        rst_n = 1;
    endtask

    task automatic test_miss_after_reset();
        dv = 1; dvpn = 27'h12345; asid = 16'd1; #1;
        vectors++;
        if (dready !== 1'b1) begin miscompares++; $display("FAIL first_ready: got %b required 1", dready); end
        step(); dv = 0;
        vectors++;
        if ({resp_valid, resp_port, resp_hit, resp_ppn, resp_perm} !== {3'b100, 44'd0, 8'd0}) begin
            miscompares++; $display("FAIL first_miss: got %b/%b/%b/%h/%h required 1/0/0/0/0",
                resp_valid, resp_port, resp_hit, resp_ppn, resp_perm);
        end
    endtask

    task automatic test_fill_hit();
        fill(27'h12345, 16'd1, 44'hABCDE, 8'hCF);
        look_d(27'h12345, 16'd1);
        vectors++;
        if ({resp_valid, resp_port, resp_hit, resp_ppn, resp_perm} !== {3'b101, 44'hABCDE, 8'hCF}) begin
            miscompares++; $display("FAIL fill_hit: got %b/%b/%h/%h required 1/1/abcde/cf",
                resp_valid, resp_hit, resp_ppn, resp_perm);
        end
        look_d(27'h12345, 16'd2);
        vectors++;
        if ({resp_valid, resp_hit, resp_ppn, resp_perm} !== {2'b10, 44'd0, 8'd0}) begin
            miscompares++; $display("FAIL asid_miss: got %b/%b/%h/%h required 1/0/0/0",
                resp_valid, resp_hit, resp_ppn, resp_perm);
        end
        fill(27'h12345, 16'd1, 44'hABCDE, 8'hEF);
        look_d(27'h12345, 16'd2);
        vectors++;
        if ({resp_valid, resp_hit, resp_ppn, resp_perm} !== {2'b11, 44'hABCDE, 8'hEF}) begin
            miscompares++; $display("FAIL global_hit: got %b/%b/%h/%h required 1/1/abcde/ef",
                resp_valid, resp_hit, resp_ppn, resp_perm);
        end
    endtask

    task automatic test_arbitration();
        dv = 1; dvpn = 27'h12345; iv = 1; ivpn = 27'h777; asid = 16'd2; #1;
        vectors++;
        if ({dready, iready} !== 2'b10) begin
            miscompares++; $display("FAIL arb_ready: got %b required 10", {dready, iready});
        end
        step(); dv = 0;
        vectors++;
        if ({resp_valid, resp_port, resp_hit, resp_ppn} !== {3'b101, 44'hABCDE}) begin
            miscompares++; $display("FAIL arb_dtlb_resp: got %b/%b/%b/%h required 1/0/1/abcde",
                resp_valid, resp_port, resp_hit, resp_ppn);
        end
        step();
        vectors++;
        if ({resp_valid, resp_port, resp_hit, resp_ppn} !== {3'b110, 44'd0}) begin
            miscompares++; $display("FAIL arb_itlb_resp: got %b/%b/%b/%h required 1/1/0/0",
                resp_valid, resp_port, resp_hit, resp_ppn);
        end
        dv = 1; fill_valid = 1; fill_vpn = 27'h777; fill_asid = 16'd2; fill_ppn = 44'h111; fill_perm = 8'h01; #1;
        vectors++;
        if ({dready, iready} !== 2'b00) begin
            miscompares++; $display("FAIL fill_blocks_ready: got %b required 00", {dready, iready});
        end
        step(); fill_valid = 0; dv = 0;
        vectors++;
        if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL fill_cycle_resp: got %b required 0", resp_valid); end
        step();
        vectors++;
        if ({resp_valid, resp_port, resp_hit, resp_ppn, resp_perm} !== {3'b111, 44'h111, 8'h01}) begin
            miscompares++; $display("FAIL fill_next_cycle: got %b/%b/%b/%h/%h required 1/1/1/111/01",
                resp_valid, resp_port, resp_hit, resp_ppn, resp_perm);
        end
        iv = 0;
    endtask

    task automatic test_plru();
        do_reset();
        fill(27'h0, 16'd1, 44'h100, 8'hCF);
        fill(27'h2, 16'd1, 44'h200, 8'hCF);
        look_d(27'h0, 16'd1);
        fill(27'h4, 16'd1, 44'h400, 8'hCF);
        look_d(27'h2, 16'd1);
        vectors++;
        if ({resp_valid, resp_hit} !== 2'b10) begin
            miscompares++; $display("FAIL plru_evicted: got %b/%b required 1/0", resp_valid, resp_hit);
        end
        look_d(27'h0, 16'd1);
        vectors++;
        if ({resp_hit, resp_ppn} !== {1'b1, 44'h100}) begin
            miscompares++; $display("FAIL plru_kept: got %b/%h required 1/100", resp_hit, resp_ppn);
        end
        look_d(27'h4, 16'd1);
        vectors++;
        if ({resp_hit, resp_ppn} !== {1'b1, 44'h400}) begin
            miscompares++; $display("FAIL plru_new: got %b/%h required 1/400", resp_hit, resp_ppn);
        end
        fill(27'h4, 16'd1, 44'h444, 8'hCF);
        look_d(27'h4, 16'd1);
        vectors++;
        if ({resp_hit, resp_ppn} !== {1'b1, 44'h444}) begin
            miscompares++; $display("FAIL refill_ppn: got %b/%h required 1/444", resp_hit, resp_ppn);
        end
        look_d(27'h0, 16'd1);
        vectors++;
        if ({resp_hit, resp_ppn} !== {1'b1, 44'h100}) begin
            miscompares++; $display("FAIL refill_no_dup: got %b/%h required 1/100", resp_hit, resp_ppn);
        end
    endtask

    task automatic test_flush();
        do_reset();
        fill(27'h10, 16'd1, 44'hA, 8'hCF);
        fill(27'h21, 16'd1, 44'hB, 8'hEF);
        fill(27'h31, 16'd2, 44'hC, 8'hCF);
        do_flush(1, 16'd1, 0, 27'h0);
        look_d(27'h10, 16'd1);
        vectors++;
        if (resp_hit !== 1'b0) begin miscompares++; $display("FAIL flush_asid_kill: got %b required 0", resp_hit); end
        look_d(27'h21, 16'd1);
        vectors++;
        if ({resp_hit, resp_ppn} !== {1'b1, 44'hB}) begin
            miscompares++; $display("FAIL flush_asid_global: got %b/%h required 1/b", resp_hit, resp_ppn);
        end
        look_d(27'h31, 16'd2);
        vectors++;
        if ({resp_hit, resp_ppn} !== {1'b1, 44'hC}) begin
            miscompares++; $display("FAIL flush_asid_other: got %b/%h required 1/c", resp_hit, resp_ppn);
        end
        do_flush(0, 16'd0, 1, 27'h21);
        look_d(27'h21, 16'd1);
        vectors++;
        if (resp_hit !== 1'b0) begin miscompares++; $display("FAIL flush_vpn_global: got %b required 0", resp_hit); end
        look_d(27'h31, 16'd2);
        vectors++;
        if (resp_hit !== 1'b1) begin miscompares++; $display("FAIL flush_vpn_other: got %b required 1", resp_hit); end
        do_flush(0, 16'd0, 0, 27'h0);
        look_d(27'h31, 16'd2);
        vectors++;
        if ({resp_valid, resp_hit} !== 2'b10) begin
            miscompares++; $display("FAIL flush_all: got %b/%b required 1/0", resp_valid, resp_hit);
        end
    endtask

    task automatic test_fill_flush_collision();
        fill_valid = 1; fill_vpn = 27'h55; fill_asid = 16'd1; fill_ppn = 44'h555; fill_perm = 8'hCF;
        do_flush(0, 16'd0, 0, 27'h0);
        fill_valid = 0;
        look_d(27'h55, 16'd1);
        vectors++;
        if ({resp_valid, resp_hit} !== 2'b10) begin
            miscompares++; $display("FAIL fill_flush_drop: got %b/%b required 1/0", resp_valid, resp_hit);
        end
    endtask

    task automatic test_reset_inflight();
        fill(27'h55, 16'd1, 44'h555, 8'hCF);
        look_d(27'h55, 16'd1);
        vectors++;
        if ({resp_valid, resp_hit} !== 2'b11) begin
            miscompares++; $display("FAIL pre_reset_hit: got %b/%b required 1/1", resp_valid, resp_hit);
        end
        dv = 1; dvpn = 27'h55; rst_n = 0;
        step(); dv = 0;
        vectors++;
        if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_inflight: got %b required 0", resp_valid); end
        rst_n = 1;
        look_d(27'h55, 16'd1);
        vectors++;
        if ({resp_valid, resp_hit} !== 2'b10) begin
            miscompares++; $display("FAIL post_reset_miss: got %b/%b required 1/0", resp_valid, resp_hit);
        end
    endtask

    task automatic test_random();
        int  r;
        bit  exp_dr, exp_ir;
        for (int n = 0; n < 800; n++) begin
            idle(); rst_n = 1;
            r = $urandom_range(0, 99);
            if (r < 2) begin
                rst_n = 0;
            end else if (r < 10) begin
                flush = 1;
                flush_asid_valid = 1'($urandom_range(0, 1)); flush_asid = 16'($urandom_range(1, 2));
                flush_vpn_valid  = 1'($urandom_range(0, 1)); flush_vpn  = 27'($urandom_range(0, 7));
                fill_valid = ($urandom_range(0, 3) == 0);
                fill_vpn = 27'($urandom_range(0, 7)); fill_asid = 16'($urandom_range(1, 2));
            end else if (r < 35) begin
                fill_valid = 1;
                fill_vpn  = 27'($urandom_range(0, 7)); fill_asid = 16'($urandom_range(1, 2));
                fill_ppn  = 44'({$urandom(), $urandom()}); fill_perm = 8'($urandom());
                dv = 1'($urandom_range(0, 1)); dvpn = 27'($urandom_range(0, 7));
            end else begin
                dv = 1'($urandom_range(0, 1)); iv = 1'($urandom_range(0, 1));
                dvpn = 27'($urandom_range(0, 7)); ivpn = 27'($urandom_range(0, 7));
                asid = 16'($urandom_range(1, 2));
            end
            #1;
            exp_dr = rst_n && !flush && !fill_valid;
            exp_ir = exp_dr && !dv;
            vectors++;
            if ({dready, iready} !== {exp_dr, exp_ir}) begin
                miscompares++; $display("FAIL rand_ready[%0d]: got %b required %b", n, {dready, iready}, {exp_dr, exp_ir});
            end
            step();
            vectors++;
            if ({resp_valid, resp_port, resp_hit, resp_ppn, resp_perm} !== {e_valid, e_port, e_hit, e_ppn, e_perm}) begin
                miscompares++;
                $display("FAIL rand_resp[%0d]: got v%b p%b h%b ppn=%h perm=%h required v%b p%b h%b ppn=%h perm=%h",
                    n, resp_valid, resp_port, resp_hit, resp_ppn, resp_perm, e_valid, e_port, e_hit, e_ppn, e_perm);
            end
        end
        idle(); rst_n = 1;
    endtask

    initial begin
        idle();
        rst_n = 0; dvpn = 0; ivpn = 0; asid = 0;
        fill_vpn = 0; fill_asid = 0; fill_ppn = 0; fill_perm = 0;
        flush_asid = 0; flush_vpn = 0;
        test_reset();
        test_miss_after_reset();
        test_fill_hit();
        test_arbitration();
        test_plru();
        test_flush();
        test_fill_flush_collision();
        test_reset_inflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
